// File: rtl/sprite_fetch_pkg.sv
// Shared definitions for the sprite ROM fetcher: FSM states and buffer geometry.
package sprite_fetch_pkg;

    localparam int BUF_DEPTH = 16;
    localparam int LEN_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/sprite_rom_fetcher_toggle_sync.sv
// toggle_sync: STAGES-deep flip-flop chain for a toggle-handshake acknowledge.
// STAGES = 0 passes the input straight through (already in the local domain).
// No reset: the chain must keep tracking the far side across a local reset.
module toggle_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_49m,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_chain
            logic [STAGES-1:0] chain;

            // shift the acknowledge through the synchroniser stages
            always_ff @(posedge clk_49m) begin
                chain[0] <= d;
                for (int unsigned i = 1; i < STAGES; i++) begin
                    chain[i] <= chain[i-1];
                end
            end

            assign q = chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/sprite_rom_fetcher.sv
// sprite_rom_fetcher: requester side of the SDRAM sprite-channel toggle handshake.
// Takes a burst command, issues one toggle request per 16-bit word, captures the
// returned words into a 16-entry buffer read by index with one cycle of latency.
// Optional macro SPRITE_FETCH_TIMEOUT_EN enables the WAIT/DRAIN watchdog and err.
module sprite_rom_fetcher
    import sprite_fetch_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_49m,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic [LEN_W-1:0]  fetch_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [3:0]        rd_idx,
    output logic [15:0]       rd_data,
    output logic              sp_req,
    input  logic              sp_ack,
    output logic [ADDR_W-1:0] sp_rom_addr,
    input  logic [15:0]       sp_rom_do
);

`ifdef SPRITE_FETCH_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t      state, state_next;
    logic              ack_s;
    logic              ack_match;
    logic              timeout_hit;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  last;
    logic [LEN_W-1:0]  idx;
    logic [CNT_W-1:0]  wcnt;
    logic [15:0]       buf_mem [BUF_DEPTH];

    toggle_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk_49m (clk_49m),
        .d       (sp_ack),
        .q       (ack_s)
    );

    assign ack_match   = (ack_s == sp_req);
    assign timeout_hit = TIMEOUT_EN && !ack_match && (wcnt == CNT_LAST)
                         && ((state == WAIT) || (state == DRAIN));

    // state register; reset with a request in flight parks in DRAIN
    always_ff @(posedge clk_49m) begin
        if (!reset) begin
            state <= ack_match ? IDLE : DRAIN;
        end else begin
            state <= state_next;
        end
    end

    // next-state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_start) state_next = ISSUE;
            end
            ISSUE: begin
                busy       = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (ack_match) begin
                    state_next = (idx == last) ? DONE : ISSUE;
                end else if (timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            DRAIN: begin
                busy = 1'b1;
                if (ack_match || timeout_hit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // command latch, address/index stepping and request address
    always_ff @(posedge clk_49m) begin
        if (!reset) begin
            sp_rom_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        cur_addr <= fetch_addr;
                        last     <= fetch_len;
                        idx      <= '0;
                    end
                end
                ISSUE: sp_rom_addr <= cur_addr;
                WAIT: begin
                    if (ack_match && (idx != last)) begin
                        idx      <= idx + 1'b1;
                        cur_addr <= cur_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // toggle request: deliberately not reset so handshake parity survives reset
    always_ff @(posedge clk_49m) begin
        if (reset) begin
            if (state == ISSUE) begin
                sp_req <= ~sp_req;
            end else if (timeout_hit) begin
                sp_req <= ack_s;
            end
        end
    end

    // watchdog counter, cleared on entry to WAIT and while in reset (DRAIN entry)
    always_ff @(posedge clk_49m) begin
        if (!reset || (state == ISSUE)) begin
            wcnt <= '0;
        end else if ((state == WAIT) || (state == DRAIN)) begin
            wcnt <= wcnt + 1'b1;
        end
    end

`ifdef SPRITE_FETCH_TIMEOUT_EN
    // sticky timeout flag, cleared by reset or an accepted command
    always_ff @(posedge clk_49m) begin
        if (!reset) begin
            err <= 1'b0;
        end else if ((state == IDLE) && fetch_start) begin
            err <= 1'b0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    // capture the returned word on the first matching compare
    always_ff @(posedge clk_49m) begin
        if (reset && (state == WAIT) && ack_match) begin
            buf_mem[idx] <= sp_rom_do;
        end
    end

    // registered buffer read port
    always_ff @(posedge clk_49m) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= buf_mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_sprite_rom_fetcher.sv
// Self-checking bench for sprite_rom_fetcher: a behavioural toggle responder on
// the SYNC_STAGES=2 instance plus a second SYNC_STAGES=0 instance with an
// immediate responder. Expected addresses and buffer contents are queued when
// commands are issued and compared when the DUT produces them.
module tb_sprite_rom_fetcher;

    logic        clk_49m = 1'b0;
    always #5 clk_49m = ~clk_49m;

    logic        reset;
    logic        fetch_start, fetch_start0;
    logic [15:0] fetch_addr;
    logic [3:0]  fetch_len;
    logic [3:0]  rd_idx;
    logic        busy, done, err;
    logic [15:0] rd_data;
    logic        sp_req, sp_ack;
    logic [15:0] sp_rom_addr, sp_rom_do;

    logic        busy0, done0, err0;
    logic [15:0] rd_data0;
    logic        sp_req0;
    logic [15:0] sp_rom_addr0;
    logic [15:0] q0;

    assign q0 = sp_rom_addr0 ^ 16'h5A5A;

    sprite_rom_fetcher #(.ADDR_W(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(8)) dut (
        .clk_49m(clk_49m), .reset(reset), .fetch_start(fetch_start),
        .fetch_addr(fetch_addr), .fetch_len(fetch_len), .busy(busy), .done(done),
        .err(err), .rd_idx(rd_idx), .rd_data(rd_data), .sp_req(sp_req),
        .sp_ack(sp_ack), .sp_rom_addr(sp_rom_addr), .sp_rom_do(sp_rom_do)
    );

    sprite_rom_fetcher #(.ADDR_W(16), .SYNC_STAGES(0), .TIMEOUT_CYCLES(8)) dut0 (
        .clk_49m(clk_49m), .reset(reset), .fetch_start(fetch_start0),
        .fetch_addr(fetch_addr), .fetch_len(fetch_len), .busy(busy0), .done(done0),
        .err(err0), .rd_idx(rd_idx), .rd_data(rd_data0), .sp_req(sp_req0),
        .sp_ack(sp_req0), .sp_rom_addr(sp_rom_addr0), .sp_rom_do(q0)
    );

    int errors = 0;
    int checks = 0;

    // scoreboard
    logic [15:0] exp_addr_q[$];
    logic [15:0] obs_addr_q[$];
    logic [15:0] exp_buf[16];
    logic        exp_req = 1'b0;
    logic        exp_err = 1'b0;

    // responder controls and state
    int          resp_lat  = 3;
    bit          resp_mode = 1'b0;     // 0: fixed word, 1: data = address
    logic [15:0] resp_fixed = 16'hBEEF;
    bit          resp_en   = 1'b1;
    logic        seen_req  = 1'b0;
    logic [15:0] req_addr  = '0;
    int          pend      = -1;
    int          toggles   = 0;
    bit          addr_moved = 1'b0;

    // behavioural SDRAM sprite channel
    initial begin
        sp_ack    = 1'b0;
        sp_rom_do = '0;
        forever begin
            @(posedge clk_49m); #1;
            if (sp_req !== seen_req) begin
                seen_req = sp_req;
                if (sp_req === sp_ack) begin
                    pend = -1;          // request abandoned by the requester
                end else begin
                    toggles++;
                    req_addr = sp_rom_addr;
                    obs_addr_q.push_back(sp_rom_addr);
                    pend = resp_lat;
                end
            end else if (pend > 0) begin
                if (sp_rom_addr !== req_addr) addr_moved = 1'b1;
                pend--;
                if (pend == 0 && resp_en) begin
                    sp_rom_do = resp_mode ? req_addr : resp_fixed;
                    sp_ack    = seen_req;
                    pend      = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_49m); #1;
    endtask

    // issue a command on the SYNC_STAGES=2 instance and follow it to done
    task automatic run_burst(input logic [15:0] a, input logic [3:0] l,
                             input int extra_at, input bit start_in_done,
                             output int busy_cycles, output int done_cnt,
                             output int busy_gaps, output bit timed_out);
        fetch_addr  = a;
        fetch_len   = l;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        busy_cycles = 0;
        done_cnt    = 0;
        busy_gaps   = 0;
        timed_out   = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (done) begin
                done_cnt++;
                timed_out = 1'b0;
                if (busy) busy_gaps++;
                break;
            end
            if (busy) busy_cycles++;
            else busy_gaps++;
            if (k == extra_at) begin
                fetch_addr  = 16'h4444;
                fetch_len   = 4'd0;
                fetch_start = 1'b1;
            end else begin
                fetch_start = 1'b0;
            end
            tick();
        end
        fetch_start = start_in_done;
        tick();
        fetch_start = 1'b0;
        if (done) done_cnt++;
    endtask

    task automatic push_burst(input logic [15:0] a, input logic [3:0] l, input bit addr_data,
                              input logic [15:0] fixed);
        logic [15:0] w;
        for (int i = 0; i <= int'(l); i++) begin
            w = a + 16'(i);
            exp_addr_q.push_back(w);
            exp_buf[i] = addr_data ? w : fixed;
            exp_req    = ~exp_req;
        end
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        fetch_start = 1'b0;
        fetch_start0 = 1'b0;
        fetch_addr  = '0;
        fetch_len   = '0;
        rd_idx      = '0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        checks++; if (sp_rom_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0000", sp_rom_addr); end
        checks++; if (sp_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", sp_req); end
        reset = 1'b1;
        tick();
    endtask

    task automatic check_addresses(input string tag);
        logic [15:0] e, o;
        checks++;
        if (obs_addr_q.size() != exp_addr_q.size()) begin
            errors++;
            $display("FAIL %s_toggles: got %0d requests want %0d", tag, obs_addr_q.size(), exp_addr_q.size());
        end
        while (exp_addr_q.size() > 0 && obs_addr_q.size() > 0) begin
            e = exp_addr_q.pop_front();
            o = obs_addr_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s_addr: got %h want %h", tag, o, e); end
        end
        exp_addr_q.delete();
        obs_addr_q.delete();
    endtask

    task automatic test_single_word();
        int bc, dc, bg; bit to;
        resp_lat = 3; resp_mode = 1'b0; resp_fixed = 16'hBEEF; addr_moved = 1'b0;
        push_burst(16'h1234, 4'd0, 1'b0, 16'hBEEF);
        run_burst(16'h1234, 4'd0, -1, 1'b0, bc, dc, bg, to);
        checks++; if (to) begin errors++; $display("FAIL single_timeout: done never seen"); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL single_done: got %0d pulses want 1", dc); end
        checks++; if (addr_moved) begin errors++; $display("FAIL single_addr_stable: got moved want stable"); end
        check_addresses("single");
        rd_idx = 4'd0;
        tick();
        checks++; if (rd_data !== 16'hBEEF) begin errors++; $display("FAIL single_rd: got %h want beef", rd_data); end
        checks++; if (sp_req !== exp_req) begin errors++; $display("FAIL single_req: got %b want %b", sp_req, exp_req); end
    endtask

    task automatic test_full_burst();
        int bc, dc, bg; bit to;
        resp_lat = 2; resp_mode = 1'b1; addr_moved = 1'b0;
        push_burst(16'h0100, 4'd15, 1'b1, 16'h0);
        run_burst(16'h0100, 4'd15, -1, 1'b0, bc, dc, bg, to);
        checks++; if (to || dc !== 1) begin errors++; $display("FAIL full_done: got %0d pulses want 1", dc); end
        checks++; if (bg !== 0) begin errors++; $display("FAIL full_busy: got %0d gaps want 0", bg); end
        checks++; if (addr_moved) begin errors++; $display("FAIL full_addr_stable: got moved want stable"); end
        check_addresses("full");
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            tick();
            checks++;
            if (rd_data !== exp_buf[i]) begin errors++; $display("FAIL full_buf[%0d]: got %h want %h", i, rd_data, exp_buf[i]); end
        end
    endtask

    task automatic test_wrap_ignored();
        int bc, dc, bg, t0; bit to;
        resp_lat = 1; resp_mode = 1'b1; addr_moved = 1'b0;
        push_burst(16'hFFFE, 4'd3, 1'b1, 16'h0);
        run_burst(16'hFFFE, 4'd3, 5, 1'b1, bc, dc, bg, to);
        checks++; if (to || dc !== 1) begin errors++; $display("FAIL wrap_done: got %0d pulses want 1", dc); end
        check_addresses("wrap");
        t0 = toggles;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_start_in_done: got busy %b want 0", busy); end
        repeat (3) tick();
        checks++; if (toggles !== t0) begin errors++; $display("FAIL wrap_no_request: got %0d want %0d", toggles, t0); end
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            tick();
            checks++;
            if (rd_data !== exp_buf[i]) begin errors++; $display("FAIL wrap_buf[%0d]: got %h want %h", i, rd_data, exp_buf[i]); end
        end
    endtask

    task automatic test_reset_mid_wait();
        int bc, dc, bg, k, pulses; bit to;
        logic r0;
        resp_lat = 10; resp_mode = 1'b0; resp_fixed = 16'hDEAD;
        r0 = sp_req;
        fetch_addr = 16'h0200; fetch_len = 4'd0; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (k = 0; k < 20 && sp_req === r0; k++) tick();
        checks++; if (sp_req === r0) begin errors++; $display("FAIL drain_issue: got no toggle want toggle"); end
        exp_req = ~exp_req;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy: got %b want 1", busy); end
        pulses = 0;
        for (k = 0; k < 60 && busy === 1'b1; k++) begin
            tick();
            if (done) pulses++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_exit: got busy %b want 0", busy); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL drain_done: got %0d pulses want 0", pulses); end
        checks++; if (sp_req !== sp_ack) begin errors++; $display("FAIL drain_parity: got req %b ack %b want equal", sp_req, sp_ack); end
        obs_addr_q.delete();
        rd_idx = 4'd0;
        tick();
        checks++; if (rd_data !== exp_buf[0]) begin errors++; $display("FAIL drain_nowrite: got %h want %h", rd_data, exp_buf[0]); end
        resp_lat = 3; resp_mode = 1'b1;
        push_burst(16'h0300, 4'd1, 1'b1, 16'h0);
        run_burst(16'h0300, 4'd1, -1, 1'b0, bc, dc, bg, to);
        checks++; if (to || dc !== 1) begin errors++; $display("FAIL after_drain_done: got %0d pulses want 1", dc); end
        check_addresses("after_drain");
        checks++; if (sp_req !== exp_req) begin errors++; $display("FAIL after_drain_req: got %b want %b", sp_req, exp_req); end
        rd_idx = 4'd1;
        tick();
        checks++; if (rd_data !== 16'h0301) begin errors++; $display("FAIL after_drain_rd: got %h want 0301", rd_data); end
    endtask

    task automatic test_timeout();
`ifdef SPRITE_FETCH_TIMEOUT_EN
        int bc, dc, bg; bit to;
        resp_en = 1'b0;
        exp_addr_q.push_back(16'h0500);
        run_burst(16'h0500, 4'd2, -1, 1'b0, bc, dc, bg, to);
        checks++; if (to || dc !== 1) begin errors++; $display("FAIL timeout_done: got %0d pulses want 1", dc); end
        checks++; if (bc !== 9) begin errors++; $display("FAIL timeout_cycles: got %0d busy cycles want 9", bc); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err); end
        check_addresses("timeout");
        tick();
        checks++; if (sp_req !== sp_ack || sp_req !== exp_req) begin errors++; $display("FAIL timeout_req: got %b want %b", sp_req, exp_req); end
        resp_en = 1'b1; resp_lat = 2; resp_mode = 1'b1;
        fetch_addr = 16'h0600; fetch_len = 4'd0; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear: got %b want 0", err); end
        exp_req = ~exp_req;
        for (int k = 0; k < 40 && !done; k++) tick();
        tick();
        obs_addr_q.delete();
`else
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_tied: got %b want 0", err); end
`endif
    endtask

    task automatic test_sync0_throughput();
        int bc; bit seen;
        fetch_addr = 16'h0A00; fetch_len = 4'd3; fetch_start0 = 1'b1;
        tick();
        fetch_start0 = 1'b0;
        bc = 0; seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done0) begin seen = 1'b1; break; end
            if (busy0) bc++;
            tick();
        end
        checks++; if (!seen) begin errors++; $display("FAIL sync0_done: got none want pulse"); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL sync0_cycles: got %0d want 8", bc); end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 4'(i);
            tick();
            checks++;
            if (rd_data0 !== ((16'h0A00 + 16'(i)) ^ 16'h5A5A)) begin
                errors++;
                $display("FAIL sync0_buf[%0d]: got %h want %h", i, rd_data0, (16'h0A00 + 16'(i)) ^ 16'h5A5A);
            end
        end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL sync0_err: got %b want 0", err0); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_burst();
        test_wrap_ignored();
        test_reset_mid_wait();
        test_timeout();
        test_sync0_throughput();
        checks++; if (err !== exp_err) begin errors++; $display("FAIL final_err: got %b want %b", err, exp_err); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
